load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the execute ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one load or store per request over a req/gnt/rvalid memory bus.
- Returns sign- or zero-extended load data and stalls the core while an access is outstanding.

Parameters:
WAIT_TIMEOUT, 255, max cycles spent in REQ or WAIT before aborting with error; 0 disables the timeout.

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents a memory instruction; held stable while busy=1
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
req_addr  in  32  effective address (ALU result)
req_wdata  in  32  store data (rs2)
busy  out  1  core stall request
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  32  formatted load data (0 for stores)
rsp_err  out  1  qualifies rsp_valid: misaligned, illegal funct3, or timeout
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  32  word-aligned address, bits [1:0] always 00
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  bus accepted request
mem_rvalid  in  1  read data valid or write acknowledge; earliest one cycle after gnt
mem_rdata  in  32  bus read data

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata = 0.
  - rsp_valid, rsp_rdata, rsp_err = 0.
  - busy is forced to 0.
  - Timeout counter = 0.
- States:
  - IDLE, REQ, WAIT, DONE.
- IDLE:
  - On req_valid, latch we, funct3, addr and wdata.
  - Illegal funct3 (loads 011/110/111; stores 011 to 111) or misaligned access -> DONE with err=1. No bus cycle is issued.
  - Otherwise, register mem_addr = {addr[31:2],2'b00}, mem_be and mem_wdata, then -> REQ.
- REQ:
  - mem_req=1 and all mem_* outputs held stable until gnt.
  - On mem_gnt: mem_req=0 on the next cycle, -> WAIT.
- WAIT:
  - On mem_rvalid:
    - Loads: shift mem_rdata right by 8*addr[1:0] and extend per funct3 into rsp_rdata.
    - Stores: rsp_rdata=0.
  - Then -> DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle, rsp_err as determined.
  - -> IDLE.
  - req_valid is ignored in DONE because it is still the retiring instruction.
- busy = (state==IDLE && req_valid) || state==REQ || state==WAIT.
  - Combinational.
  - busy=0 in DONE so the core advances at the end of that cycle.
- Latency:
  - Zero-wait bus (gnt in first REQ cycle, rvalid the cycle after): accept in cycle 0, REQ in 1, WAIT in 2, rsp_valid in 3.
  - Error without a bus cycle: rsp_valid in cycle 1.
- Byte enables and store data:
  - SB: be=0001<<addr[1:0], wdata={4{b}}.
  - SH: be=0011<<addr[1:0], wdata={2{h}}.
  - SW: be=1111.
  - Loads use the same be pattern.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
- Timeout:
  - Counter clears on entry to REQ and to WAIT, and increments each cycle in those states.
  - Reaching WAIT_TIMEOUT -> mem_req=0, DONE with err=1, rsp_rdata=0.
  - If WAIT_TIMEOUT=0, no timeout applies.
- mem_rvalid in IDLE, REQ or DONE (e.g. stale after reset) is ignored.
- Reset mid-access abandons the transaction. No response is generated.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access produces rsp_err with no bus cycle, as described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misalignment is not an error.
  - The offending low address bits are cleared: halfword forces addr[0]=0, word forces addr[1:0]=00.
  - The access then proceeds normally.
  - Illegal funct3 still produces rsp_err.

Test Plan:
- LW addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> mem_addr=0x100, be=1111, rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, err=0, busy high in cycles 0 to 2.
- LB addr 0x103, rdata 0x80112233 -> be=1000, rsp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD -> mem_we=1, mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD, rsp_valid after rvalid, rsp_rdata=0.
- LW addr 0x101:
  - With macro: no mem_req, rsp_valid+rsp_err in cycle 1.
  - Without macro: mem_addr=0x100, be=1111, err=0.
- WAIT_TIMEOUT=4, gnt held low -> mem_req for 4 cycles, then rsp_valid+rsp_err, rsp_rdata=0. req_valid with funct3=011 -> immediate err.
- Assert rst_n low while in WAIT, then send a stray rvalid after release -> all outputs 0, state IDLE, no rsp_valid. The next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store stage: one memory access per request over a req/gnt/rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors; by default the low address bits are cleared instead.
module load_store_unit #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (WAIT_TIMEOUT > 0) ? CW'(WAIT_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        illegal, dec_err, timeout_hit;
    logic [31:0] addr_adj, wdata_fmt, shifted, load_fmt;
    logic [3:0]  be_base, be;

    // Stores only have widths 000..010; loads additionally allow 100/101.
    assign illegal = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign addr_adj = req_addr;
    assign dec_err  = illegal || misalign;
`else
    always_comb begin
        addr_adj = req_addr;
        if (req_funct3[1:0] == 2'b01) addr_adj[0] = 1'b0;
        if (req_funct3[1:0] == 2'b10) addr_adj[1:0] = 2'b00;
    end
    assign dec_err = illegal;
`endif

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   begin be_base = 4'b0001; wdata_fmt = {4{req_wdata[7:0]}};  end
            2'b01:   begin be_base = 4'b0011; wdata_fmt = {2{req_wdata[15:0]}}; end
            default: begin be_base = 4'b1111; wdata_fmt = req_wdata;            end
        endcase
    end
    assign be = be_base << addr_adj[1:0];

    assign shifted = mem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (funct3_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'b0, shifted[7:0]};
            3'b101:  load_fmt = {16'b0, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    assign timeout_hit = (WAIT_TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d     = req_we;
                funct3_d = req_funct3;
                off_d    = addr_adj[1:0];
                err_d    = dec_err;
                rdata_d  = '0;
                if (dec_err) begin
                    state_d = DONE;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we;
                    mem_addr_d  = {addr_adj[31:2], 2'b00};
                    mem_be_d    = be;
                    mem_wdata_d = wdata_fmt;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = we_q ? 32'b0 : load_fmt;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // rst_n gating keeps the stall low while reset holds the FSM in IDLE.
    assign busy      = rst_n && ((state_q == IDLE && req_valid) || state_q == REQ || state_q == WAIT);
    assign rsp_valid = (state_q == DONE);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses queued at issue, compared on rsp_valid.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int          n_chk = 0, n_err = 0;
    logic [32:0] sb_q[$];
    logic [32:0] sb_e;

    load_store_unit #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_spurious_rsp", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, sb_e[31:0]);
                chk("rsp_err", 32'(rsp_err), 32'(sb_e[32]));
            end
        end
    end

    // mode: 0 normal bus, 1 never grant, 2 grant but never rvalid
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, wdata, bus_rd,
                       input int mode, input int exp_reqc, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd, exp_rd,
                       input logic exp_err, input int exp_cyc);
        int cyc, reqc;
        bit granted, rv_sent, seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        sb_q.push_back({exp_err, exp_rd});
        #1 chk("busy_accept", 32'(busy), 32'd1);
        cyc = 0; reqc = 0; granted = 0; rv_sent = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (rsp_valid) begin
                seen = 1;
                chk("rsp_cycle", 32'(cyc), 32'(exp_cyc));
                chk("busy_done", 32'(busy), 32'd0);
                chk("req_cycles", 32'(reqc), 32'(exp_reqc));
                req_valid = 1'b0;
            end else begin
                chk("busy_stall", 32'(busy), 32'd1);
                if (mem_req) begin
                    if (reqc == 0) begin
                        chk("mem_addr", mem_addr, exp_addr);
                        chk("mem_be", 32'(mem_be), 32'(exp_be));
                        chk("mem_we", 32'(mem_we), 32'(we));
                        if (we) chk("mem_wdata", mem_wdata, exp_wd);
                    end
                    reqc++;
                    if (mode != 1) begin mem_gnt = 1'b1; granted = 1; end
                end else if (granted && !rv_sent && mode == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = bus_rd; rv_sent = 1;
                end
            end
        end
        if (!seen) begin
            chk("rsp_wait_expired", 32'd0, 32'd1);
            req_valid = 1'b0;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //  we    f3      addr          wdata          bus_rd      mode reqc exp_addr      be       exp_wd         exp_rd         err cyc
        txn(1'b0, 3'b010, 32'h100, 32'h0,          32'hDEADBEEF, 0, 1, 32'h100, 4'b1111, 32'h0,         32'hDEADBEEF, 1'b0, 3);
        txn(1'b0, 3'b000, 32'h103, 32'h0,          32'h80112233, 0, 1, 32'h100, 4'b1000, 32'h0,         32'hFFFFFF80, 1'b0, 3);
        txn(1'b0, 3'b100, 32'h103, 32'h0,          32'h80112233, 0, 1, 32'h100, 4'b1000, 32'h0,         32'h00000080, 1'b0, 3);
        txn(1'b1, 3'b001, 32'h202, 32'h0000ABCD,  32'h12345678, 0, 1, 32'h200, 4'b1100, 32'hABCDABCD,  32'h0,         1'b0, 3);
        txn(1'b0, 3'b001, 32'h102, 32'h0,          32'h80010000, 0, 1, 32'h100, 4'b1100, 32'h0,         32'hFFFF8001, 1'b0, 3);
        txn(1'b0, 3'b101, 32'h102, 32'h0,          32'h80010000, 0, 1, 32'h100, 4'b1100, 32'h0,         32'h00008001, 1'b0, 3);
        txn(1'b1, 3'b000, 32'h101, 32'h123456A5,  32'h0,        0, 1, 32'h100, 4'b0010, 32'hA5A5A5A5,  32'h0,         1'b0, 3);
        txn(1'b1, 3'b010, 32'h204, 32'h11223344,  32'h0,        0, 1, 32'h204, 4'b1111, 32'h11223344,  32'h0,         1'b0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
        txn(1'b0, 3'b010, 32'h101, 32'h0,          32'hCAFEF00D, 0, 0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 1);
        txn(1'b0, 3'b001, 32'h101, 32'h0,          32'h00009876, 0, 0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 1);
`else
        txn(1'b0, 3'b010, 32'h101, 32'h0,          32'hCAFEF00D, 0, 1, 32'h100, 4'b1111, 32'h0,         32'hCAFEF00D, 1'b0, 3);
        txn(1'b0, 3'b001, 32'h101, 32'h0,          32'h00009876, 0, 1, 32'h100, 4'b0011, 32'h0,         32'hFFFF9876, 1'b0, 3);
`endif
        // Timeouts: stuck in REQ (4 request cycles), then stuck in WAIT.
        txn(1'b0, 3'b010, 32'h300, 32'h0,          32'h0,        1, 4, 32'h300, 4'b1111, 32'h0,         32'h0,         1'b1, 5);
        txn(1'b0, 3'b010, 32'h300, 32'h0,          32'h0,        2, 1, 32'h300, 4'b1111, 32'h0,         32'h0,         1'b1, 6);
        // Illegal width codes never reach the bus.
        txn(1'b0, 3'b011, 32'h100, 32'h0,          32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 1);
        txn(1'b0, 3'b110, 32'h100, 32'h0,          32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 1);
        txn(1'b1, 3'b011, 32'h100, 32'h0,          32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 1);
        txn(1'b1, 3'b100, 32'h100, 32'h0,          32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,         32'h0,         1'b1, 1);

        // Reset while WAITing, then a stray rvalid must not produce a response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_be", 32'(mem_be), 32'd0);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("stray_rsp_valid2", 32'(rsp_valid), 32'd0);
        txn(1'b0, 3'b010, 32'h100, 32'h0,          32'h0BADF00D, 0, 1, 32'h100, 4'b1111, 32'h0,         32'h0BADF00D, 1'b0, 3);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
